// File: rtl/corelet_pkg.sv
// Shared state encoding, layer defaults and SRAM enable levels for the corelet sequencer.
package corelet_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StIdle  = 4'd0;
    localparam state_t StWFill = 4'd1;
    localparam state_t StWLoad = 4'd2;
    localparam state_t StWGap  = 4'd3;
    localparam state_t StXFill = 4'd4;
    localparam state_t StXExec = 4'd5;
    localparam state_t StDrain = 4'd6;
    localparam state_t StAcc   = 4'd7;
    localparam state_t StFin   = 4'd8;

    localparam int unsigned DefKij   = 9;
    localparam int unsigned DefNij   = 36;
    localparam int unsigned DefWbase = 1024;

    localparam logic SramOn  = 1'b0;
    localparam logic SramOff = 1'b1;

endpackage

// File: rtl/ctrl_addr_gen.sv
// Loadable SRAM address register: captures base+offset when loaded, zero when cleared.
module ctrl_addr_gen #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] base,
    input  logic [W-1:0] offset,
    output logic [W-1:0] addr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (ld) begin
            addr <= base + offset;
        end
    end

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet layer sequencer: weight fill/load, activation fill/execute, OFIFO drain per kernel
// position. Define CORELET_CTRL_ACC_EN to add the psum accumulation read pass before FIN.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned KIJ     = DefKij,
    parameter int unsigned NIJ     = DefNij,
    parameter int unsigned XADDR_W = 11,
    parameter int unsigned PADDR_W = 11,
    parameter int unsigned WBASE   = DefWbase
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               l0_full,
    input  logic               ofifo_valid,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic               load,
    output logic               execute,
    output logic               ofifo_rd,
    output logic               acc,
    output logic               xmem_cen,
    output logic [XADDR_W-1:0] xmem_addr,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [PADDR_W-1:0] pmem_addr,
    output logic [3:0]         kij_idx,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(NIJ + row + col + KIJ + 2);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, units, phase_len;
    logic               act_q, act_d;
    logic [3:0]         kij_q, kij_d;
    logic               wr_d, rd_d, load_d, exec_d, ofrd_d, pcen_d, pwen_d, done_d;
    logic               xld, pld, clr;
    logic [XADDR_W-1:0] x_base, x_off;
    logic [PADDR_W-1:0] p_base, p_off;

`ifdef CORELET_CTRL_ACC_EN
    localparam int unsigned OW = $clog2(NIJ);
    logic [OW-1:0] acc_o_q, acc_o_d;
    logic          acc_rd_q, acc_rd_d;
`endif

    assign kij_idx = kij_q;

    // cnt_q counts units finished before the current cycle; act_q marks a unit finishing now.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kij_d   = kij_q;
        units   = cnt_q + CW'(act_q);
`ifdef CORELET_CTRL_ACC_EN
        acc_o_d = acc_o_q;
`endif
        case (state_q)
            StWFill, StWLoad:           phase_len = CW'(col);
            StWGap:                     phase_len = CW'(row + col);
            StXFill, StXExec, StDrain:  phase_len = CW'(NIJ);
            StAcc:                      phase_len = CW'(KIJ + 1);
            default:                    phase_len = CW'(1);
        endcase

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWFill;
                    kij_d   = '0;
                    cnt_d   = '0;
                end
            end
            StFin: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                cnt_d = units;
                if (units == phase_len) begin
                    cnt_d = '0;
                    case (state_q)
                        StWFill: state_d = StWLoad;
                        StWLoad: state_d = StWGap;
                        StWGap:  state_d = StXFill;
                        StXFill: state_d = StXExec;
                        StXExec: state_d = StDrain;
                        StDrain: begin
                            if (kij_q == 4'(KIJ - 1)) begin
`ifdef CORELET_CTRL_ACC_EN
                                state_d = StAcc;
                                acc_o_d = '0;
`else
                                state_d = StFin;
`endif
                            end else begin
                                kij_d   = kij_q + 4'd1;
                                state_d = StWFill;
                            end
                        end
`ifdef CORELET_CTRL_ACC_EN
                        StAcc: begin
                            if (acc_o_q == OW'(NIJ - 1)) state_d = StFin;
                            else acc_o_d = acc_o_q + OW'(1);
                        end
`endif
                        default: state_d = StIdle;
                    endcase
                end
            end
        endcase
    end

    // Strobes for the coming cycle, decided from the next state and the inputs sampled now.
    always_comb begin
        act_d  = 1'b0;
        wr_d   = 1'b0;
        rd_d   = 1'b0;
        load_d = 1'b0;
        exec_d = 1'b0;
        ofrd_d = 1'b0;
        pcen_d = SramOff;
        pwen_d = SramOff;
        done_d = 1'b0;
        xld    = 1'b0;
        pld    = 1'b0;
        x_base = '0;
        x_off  = '0;
        p_base = '0;
        p_off  = '0;
        clr    = (state_d == StIdle);
`ifdef CORELET_CTRL_ACC_EN
        acc_rd_d = 1'b0;
`endif
        case (state_d)
            StWFill, StXFill: begin
                act_d  = ~l0_full;
                wr_d   = ~l0_full;
                xld    = ~l0_full;
                x_base = (state_d == StWFill) ? XADDR_W'(WBASE + kij_d * col) : '0;
                x_off  = XADDR_W'(cnt_d);
            end
            StWLoad: begin
                act_d  = 1'b1;
                rd_d   = 1'b1;
                load_d = 1'b1;
            end
            StWGap: act_d = 1'b1;
            StXExec: begin
                act_d  = 1'b1;
                rd_d   = 1'b1;
                exec_d = 1'b1;
            end
            StDrain: begin
                act_d  = ofifo_valid;
                ofrd_d = ofifo_valid;
                pcen_d = ofifo_valid ? SramOn : SramOff;
                pwen_d = ofifo_valid ? SramOn : SramOff;
                pld    = ofifo_valid;
                p_base = PADDR_W'(kij_d * NIJ);
                p_off  = PADDR_W'(cnt_d);
            end
`ifdef CORELET_CTRL_ACC_EN
            StAcc: begin
                act_d = 1'b1;
                // Last slot of each output is idle to absorb the trailing acc pulse.
                if (cnt_d < CW'(KIJ)) begin
                    acc_rd_d = 1'b1;
                    pcen_d   = SramOn;
                    pld      = 1'b1;
                    p_base   = PADDR_W'(cnt_d * NIJ);
                    p_off    = PADDR_W'(acc_o_d);
                end
            end
`endif
            StFin: begin
                act_d  = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            act_q    <= 1'b0;
            kij_q    <= '0;
            l0_wr    <= 1'b0;
            l0_rd    <= 1'b0;
            load     <= 1'b0;
            execute  <= 1'b0;
            ofifo_rd <= 1'b0;
            xmem_cen <= SramOff;
            pmem_cen <= SramOff;
            pmem_wen <= SramOff;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_q    <= act_d;
            kij_q    <= kij_d;
            l0_wr    <= wr_d;
            l0_rd    <= rd_d;
            load     <= load_d;
            execute  <= exec_d;
            ofifo_rd <= ofrd_d;
            xmem_cen <= wr_d ? SramOn : SramOff;
            pmem_cen <= pcen_d;
            pmem_wen <= pwen_d;
            busy     <= (state_d != StIdle);
            done     <= done_d;
        end
    end

`ifdef CORELET_CTRL_ACC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_o_q  <= '0;
            acc_rd_q <= 1'b0;
            acc      <= 1'b0;
        end else begin
            acc_o_q  <= acc_o_d;
            acc_rd_q <= acc_rd_d;
            acc      <= acc_rd_q;
        end
    end
`else
    assign acc = 1'b0;
`endif

    ctrl_addr_gen #(
        .W(XADDR_W)
    ) u_xaddr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .ld    (xld),
        .base  (x_base),
        .offset(x_off),
        .addr  (xmem_addr)
    );

    ctrl_addr_gen #(
        .W(PADDR_W)
    ) u_paddr (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .ld    (pld),
        .base  (p_base),
        .offset(p_off),
        .addr  (pmem_addr)
    );

endmodule

// File: tb/tb_corelet_ctrl.sv
// Bench for corelet_ctrl: clean, stalled, randomized and aborted layers against a phase-level
// model. Honours CORELET_CTRL_ACC_EN when the DUT is built with it.
module tb_corelet_ctrl;

    localparam int Row    = 8;
    localparam int Col    = 8;
    localparam int Kij    = 9;
    localparam int Nij    = 36;
    localparam int Wbase  = 1024;
    localparam int MaxCyc = 6000;
`ifdef CORELET_CTRL_ACC_EN
    localparam int AccCycles = Nij * (Kij + 1);
`else
    localparam int AccCycles = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, l0_full, ofifo_valid;
    logic        l0_wr, l0_rd, load, execute, ofifo_rd, acc;
    logic        xmem_cen, pmem_cen, pmem_wen, busy, done;
    logic [10:0] xmem_addr, pmem_addr;
    logic [3:0]  kij_idx;

    bit full_h[MaxCyc];
    bit valid_h[MaxCyc];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    corelet_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .l0_full    (l0_full),
        .ofifo_valid(ofifo_valid),
        .l0_wr      (l0_wr),
        .l0_rd      (l0_rd),
        .load       (load),
        .execute    (execute),
        .ofifo_rd   (ofifo_rd),
        .acc        (acc),
        .xmem_cen   (xmem_cen),
        .xmem_addr  (xmem_addr),
        .pmem_cen   (pmem_cen),
        .pmem_wen   (pmem_wen),
        .pmem_addr  (pmem_addr),
        .kij_idx    (kij_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_q(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) check(tag, got[i], exp[i]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_strobes"}, int'({l0_wr, l0_rd, load, execute, ofifo_rd, acc, busy, done}), 0);
        check({tag, "_cens"}, int'({xmem_cen, pmem_cen, pmem_wen}), 7);
        check({tag, "_addr"}, int'(xmem_addr) + int'(pmem_addr) + int'(kij_idx), 0);
    endtask

    // Slot t is worked only if the input sampled at the edge before it allows progress.
    function automatic int consume(input int t0, input int n, input bit use_valid);
        int t = t0;
        int got = 0;
        while (got < n && t < MaxCyc) begin
            if (use_valid ? valid_h[t-1] : !full_h[t-1]) got++;
            t++;
        end
        return t;
    endfunction

    function automatic int model_done_cycle();
        int t = 1;
        for (int k = 0; k < Kij; k++) begin
            t = consume(t, Col, 1'b0);
            t += Col + Row + Col;
            t = consume(t, Nij, 1'b0);
            t += Nij;
            t = consume(t, Nij, 1'b1);
        end
        return t + AccCycles;
    endfunction

    // mode 0: clean, 1: l0_full pulse at X word 10, 2: random stalls, 3: abort in X_EXEC kij 4
    task automatic run(input int mode);
        int wq[$], pq[$], rq[$], kq[$], ew[$], ep[$], er[$], ek[$];
        int cyc, done_cyc, n_load, n_exec, n_acc, pulse, last_load0, first_x0, w9, w10;
        bit aborted, prev_rd;
        done_cyc = -1; n_load = 0; n_exec = 0; n_acc = 0; pulse = 0;
        last_load0 = 0; first_x0 = 0; w9 = 0; w10 = 0; aborted = 0; prev_rd = 0;
        @(negedge clk);
        start = 1'b1; l0_full = 1'b0; ofifo_valid = 1'b1;
        full_h[0] = 1'b0; valid_h[0] = 1'b1;
        cyc = 0;
        while (cyc < MaxCyc - 1 && done_cyc < 0 && !aborted) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", int'(busy), 1);
                check("first_wr", int'(l0_wr), 1);
                check("first_wr_addr", int'(xmem_addr), Wbase);
                check("first_kij", int'(kij_idx), 0);
            end
            check("xmem_cen", int'(xmem_cen), int'(!l0_wr));
            check("l0_rd", int'(l0_rd), int'(load | execute));
            check("busy", int'(busy), 1);
            if (l0_wr) begin
                wq.push_back(int'(xmem_addr));
                check("wr_when_full", int'(full_h[cyc-1]), 0);
            end
            if (ofifo_rd) begin
                pq.push_back(int'(pmem_addr));
                check("pmem_wr_en", int'({pmem_cen, pmem_wen}), 0);
                check("rd_without_valid", int'(valid_h[cyc-1]), 1);
            end
`ifdef CORELET_CTRL_ACC_EN
            else if (!pmem_cen) begin
                rq.push_back(int'(pmem_addr));
                check("acc_rd_wen", int'(pmem_wen), 1);
            end
            if (acc) begin
                n_acc++;
                check("acc_align", int'(prev_rd), 1);
            end
            prev_rd = !pmem_cen && pmem_wen;
`else
            else check("pmem_cen_idle", int'(pmem_cen), 1);
            check("acc_tied", int'(acc), 0);
`endif
            if (load) begin
                n_load++;
                if (kij_idx == 0) last_load0 = cyc;
            end
            if (execute) n_exec++;
            if (l0_wr && kij_idx == 0 && xmem_addr == 0) first_x0 = cyc;
            if (kq.size() == 0 || kq[$] != int'(kij_idx)) kq.push_back(int'(kij_idx));
            if (done) done_cyc = cyc;

            l0_full = 1'b0;
            ofifo_valid = 1'b1;
            case (mode)
                1: begin
                    if (l0_wr && kij_idx == 0 && xmem_addr == 9) begin
                        w9 = cyc;
                        pulse = 3;
                    end
                    if (l0_wr && kij_idx == 0 && xmem_addr == 10) w10 = cyc;
                    if (pulse > 0) begin
                        l0_full = 1'b1;
                        pulse--;
                    end
                end
                2: begin
                    l0_full = ($urandom_range(0, 3) == 0);
                    ofifo_valid = ($urandom_range(0, 3) != 0);
                    start = (!done && $urandom_range(0, 15) == 0);
                end
                3: begin
                    if (execute && kij_idx == 4) begin
                        reset = 1'b0;
                        #1;
                        check_reset_vals("abort");
                        aborted = 1'b1;
                    end
                end
                default: ;
            endcase
            full_h[cyc] = l0_full;
            valid_h[cyc] = ofifo_valid;
        end
        start = 1'b0;

        if (mode == 3) begin
            check("abort_reached", int'(aborted), 1);
            check("abort_no_done", done_cyc, -1);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_reset_vals("after_abort");
            return;
        end

        check("done_seen", int'(done_cyc >= 0), 1);
        check("done_latency", done_cyc, model_done_cycle());
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after_done", int'(busy), 0);

        for (int k = 0; k < Kij; k++) begin
            ek.push_back(k);
            for (int i = 0; i < Col; i++) ew.push_back(Wbase + k * Col + i);
            for (int i = 0; i < Nij; i++) ew.push_back(i);
            for (int j = 0; j < Nij; j++) ep.push_back(k * Nij + j);
        end
        check_q("xmem_wr_addr", wq, ew);
        check_q("pmem_wr_addr", pq, ep);
        check_q("kij_seq", kq, ek);
        check("load_cycles", n_load, Kij * Col);
        check("exec_cycles", n_exec, Kij * Nij);
`ifdef CORELET_CTRL_ACC_EN
        for (int o = 0; o < Nij; o++)
            for (int k = 0; k < Kij; k++) er.push_back(k * Nij + o);
        check_q("acc_rd_addr", rq, er);
        check("acc_pulses", n_acc, Kij * Nij);
`endif
        if (mode == 0) begin
            check("latency_total", done_cyc + 1, 1262 + AccCycles);
            check("gap_cycles", first_x0 - last_load0 - 1, Row + Col);
        end
        if (mode == 1) check("stall_word10", w10 - w9, 4);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        l0_full = 1'b0;
        ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle");
        run(0);
        run(1);
        run(2);
        run(3);
        run(0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
